pixel_bin_feeder: RTL and testbench

//  Upstream stage of the 256-bin histogram/CDF counter bank. Accepts an 8-bit

---
 rtl/pixel_bin_feeder.sv | 170 +++++++++++++++++
 tb/tb_pixel_bin_feeder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_bin_feeder.sv
// rtl/pixel_bin_feeder.sv - pixel stream to one-hot histogram bin increment enables
//
// Purpose:
//   Front end of the histogram counter bank. A start command opens a frame:
//   the bank is cleared for one cycle, then pixels are accepted on a
//   valid/ready handshake until the beat tagged end-of-frame. Each accepted
//   pixel raises exactly one bit of counter_en one cycle later. Once the last
//   enable has retired, frame_done presents the frame pixel total and the
//   saturation flag until the consumer acknowledges or opens a new frame.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_clear        synchronous active-high reset; also clears the bank
//   i_start_frame  one-cycle command: begin a new frame (IDLE or DONE only)
//   i_pix_data     pixel intensity, PIXEL_W bits
//   i_pix_valid    i_pix_data is valid
//   i_pix_eof      current beat is the last pixel of the frame
//   o_pix_ready    beat accepted when i_pix_valid & o_pix_ready
//   o_hist_clear   clear to the counter bank
//   o_counter_en   one-hot increment enables, BINS bits, registered
//   o_frame_done   frame complete; o_pix_count / o_sat_err are final
//   i_done_ack     consumer acknowledges o_frame_done
//   o_pix_count    pixels accepted in the current/last frame (saturating)
//   o_sat_err      sticky: frame carried more than MAX_PIX pixels
//   o_busy         feeder is not idle

module pixel_bin_feeder #(
   parameter int PIXEL_W = 8,
   parameter int BINS    = 2**PIXEL_W,
   parameter int CNT_W   = 15,
   parameter int MAX_PIX = 2**CNT_W - 1
) (
   input  logic               i_clk,
   input  logic               i_clear,
   input  logic               i_start_frame,
   input  logic [PIXEL_W-1:0] i_pix_data,
   input  logic               i_pix_valid,
   input  logic               i_pix_eof,
   output logic               o_pix_ready,
   output logic               o_hist_clear,
   output logic [BINS-1:0]    o_counter_en,
   output logic               o_frame_done,
   input  logic               i_done_ack,
   output logic [CNT_W-1:0]   o_pix_count,
   output logic               o_sat_err,
   output logic               o_busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLR    = 3'd1,
      S_ACTIVE = 3'd2,
      S_FLUSH  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next_state;

   logic [BINS-1:0]     r_counter_en;
   logic [CNT_W-1:0]    r_pix_count;
   logic                r_sat_err;

   logic                w_ready;
   logic                w_accept;
   logic                w_sat_hit;
   logic                w_frame_open;
   logic [BINS-1:0]     w_onehot;

   // Ready is withheld during a reset cycle so an aborted frame cannot
   // consume a beat on the very edge that returns the FSM to IDLE.
   assign w_ready      = (r_state == S_ACTIVE) && !i_clear;
   assign w_accept     = i_pix_valid && w_ready;
   assign w_sat_hit    = (r_pix_count == CNT_W'(MAX_PIX));
   assign w_onehot     = {{(BINS-1){1'b0}}, 1'b1} << i_pix_data;

   // Statistics are zeroed on the edge that enters CLR, so they already
   // read zero while the bank is being cleared.
   assign w_frame_open = (w_next_state == S_CLR) && (r_state != S_CLR);

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start_frame) begin
               w_next_state = S_CLR;
            end
         end
         S_CLR: begin
            w_next_state = S_ACTIVE;
         end
         S_ACTIVE: begin
            // A suppressed (saturated) beat still ends the frame.
            if (w_accept && i_pix_eof) begin
               w_next_state = S_FLUSH;
            end
         end
         S_FLUSH: begin
            w_next_state = S_DONE;
         end
         S_DONE: begin
            // A new start wins over an acknowledge: back-to-back frames.
            if (i_start_frame) begin
               w_next_state = S_CLR;
            end else if (i_done_ack) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------
   always_comb begin
      o_hist_clear = i_clear || (r_state == S_CLR);
      o_pix_ready  = w_ready;
      o_frame_done = (r_state == S_DONE) && !i_clear;
      o_busy       = (r_state != S_IDLE) && !i_clear;
   end

   // ---------------------------------------------------------------
   // Datapath: enables, pixel count, saturation flag
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         r_counter_en <= '0;
         r_pix_count  <= '0;
         r_sat_err    <= 1'b0;
      end else begin
         r_counter_en <= '0;
         if (w_frame_open) begin
            r_pix_count <= '0;
            r_sat_err   <= 1'b0;
         end else if (w_accept) begin
            if (w_sat_hit) begin
               // Count is pinned and the enable dropped so no bin can wrap.
               r_sat_err <= 1'b1;
            end else begin
               r_pix_count  <= r_pix_count + 1'b1;
               r_counter_en <= w_onehot;
            end
         end
      end
   end

   // A reset cycle also clears the bank, so any enable still in flight from
   // the previous edge is masked rather than racing the clear.
   assign o_counter_en = r_counter_en & {BINS{!i_clear}};
   assign o_pix_count  = i_clear ? '0 : r_pix_count;
   assign o_sat_err    = r_sat_err && !i_clear;

endmodule

// File: tb/tb_pixel_bin_feeder.sv
// tb/tb_pixel_bin_feeder.sv - self-checking bench for pixel_bin_feeder

module tb_pixel_bin_feeder;

   localparam int PIXEL_W = 8;
   localparam int BINS    = 256;
   localparam int CNT_W   = 15;
   localparam int MAX_PIX = 32767;

   logic               i_clk;
   logic               i_clear;
   logic               i_start_frame;
   logic [PIXEL_W-1:0] i_pix_data;
   logic               i_pix_valid;
   logic               i_pix_eof;
   logic               o_pix_ready;
   logic               o_hist_clear;
   logic [BINS-1:0]    o_counter_en;
   logic               o_frame_done;
   logic               i_done_ack;
   logic [CNT_W-1:0]   o_pix_count;
   logic               o_sat_err;
   logic               o_busy;

   pixel_bin_feeder #(
      .PIXEL_W (PIXEL_W),
      .BINS    (BINS),
      .CNT_W   (CNT_W),
      .MAX_PIX (MAX_PIX)
   ) dut (
      .i_clk         (i_clk),
      .i_clear       (i_clear),
      .i_start_frame (i_start_frame),
      .i_pix_data    (i_pix_data),
      .i_pix_valid   (i_pix_valid),
      .i_pix_eof     (i_pix_eof),
      .o_pix_ready   (o_pix_ready),
      .o_hist_clear  (o_hist_clear),
      .o_counter_en  (o_counter_en),
      .o_frame_done  (o_frame_done),
      .i_done_ack    (i_done_ack),
      .o_pix_count   (o_pix_count),
      .o_sat_err     (o_sat_err),
      .o_busy        (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // One row = one clock cycle: inputs driven, state-level outputs expected.
   typedef struct {
      int start;
      int valid;
      int data;
      int eof;
      int ack;
      int e_ready;
      int e_hclr;
      int e_done;
      int e_busy;
      int chk;
      int e_cnt;
      int e_sat;
   } vec_t;

   typedef struct {
      logic [7:0] bin;
      int         due;
   } sb_t;

   vec_t vt [25];
   sb_t  sb_q [$];
   int   n_vec;
   int   n_err;
   int   cyc;
   int   model_cnt;
   int   bit3_pulses;
   bit   watch_no_done;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Scoreboard: each accepted, non-saturated beat expects its bin one
   // cycle later; every other cycle must show all-zero enables.
   task automatic monitor();
      sb_t e;
      forever begin
         @(negedge i_clk);
         cyc++;
         if ($countones(o_counter_en) > 1) begin
            n_err++;
            $display("FAIL en_onehot: got %0d bits set expected at most 1", $countones(o_counter_en));
         end
         if (o_hist_clear && (o_counter_en != '0)) begin
            n_err++;
            $display("FAIL en_during_clear: got %h expected 0", o_counter_en);
         end
         if (watch_no_done && o_frame_done) begin
            n_err++;
            $display("FAIL abort_done: got frame_done 1 expected 0");
         end
         if (o_counter_en[3]) bit3_pulses++;
         if (o_hist_clear) model_cnt = 0;
         if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            // An enable due in a reset cycle is cancelled by the bank clear.
            if (!i_clear) begin
               n_vec++;
               if (o_counter_en !== (BINS'(1) << e.bin)) begin
                  n_err++;
                  $display("FAIL sb_bin: got counter_en %h expected bit %0d", o_counter_en, e.bin);
               end
            end
         end else if (o_counter_en != '0) begin
            n_err++;
            $display("FAIL en_spurious: got %h expected 0 at cycle %0d", o_counter_en, cyc);
         end
         if (i_pix_valid && o_pix_ready && model_cnt < MAX_PIX) begin
            sb_q.push_back('{i_pix_data, cyc + 1});
            model_cnt++;
         end
      end
   endtask

   task automatic cyc_step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic start_pulse();
      i_start_frame = 1'b1;
      cyc_step();
      i_start_frame = 1'b0;
   endtask

   task automatic send_beat(input logic [7:0] d, input logic e);
      bit ok;
      ok = 1'b0;
      i_pix_valid = 1'b1;
      i_pix_data  = d;
      i_pix_eof   = e;
      for (int k = 0; k < 16; k++) begin
         @(negedge i_clk);
         if (o_pix_ready) ok = 1'b1;
         @(posedge i_clk);
         #1;
         if (ok) break;
      end
      if (!ok) chk("beat_accept_timeout", 0, 1);
      i_pix_valid = 1'b0;
      i_pix_eof   = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int exp_cnt, input int exp_sat);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge i_clk);
         if (o_frame_done) begin
            seen = 1'b1;
            break;
         end
      end
      chk({nm, "_done_seen"}, int'(seen), 1);
      chk({nm, "_count"}, int'(o_pix_count), exp_cnt);
      chk({nm, "_sat"}, int'(o_sat_err), exp_sat);
      cyc_step();
   endtask

   task automatic ack_done();
      i_done_ack = 1'b1;
      cyc_step();
      i_done_ack = 1'b0;
   endtask

   initial begin
      int p0;
      // start valid data eof ack | ready hclr done busy | chk cnt sat
      vt = '{
         // single frame 0,255,7,7(eof)
         '{1, 0,   0, 0, 0,  0, 0, 0, 0,  1, 0, 0},
         '{0, 0,   0, 0, 0,  0, 1, 0, 1,  1, 0, 0},
         '{0, 1,   0, 0, 0,  1, 0, 0, 1,  1, 0, 0},
         '{0, 1, 255, 0, 0,  1, 0, 0, 1,  1, 1, 0},
         '{0, 1,   7, 0, 0,  1, 0, 0, 1,  0, 0, 0},
         '{0, 1,   7, 1, 0,  1, 0, 0, 1,  1, 3, 0},
         '{0, 0,   0, 0, 0,  0, 0, 0, 1,  1, 4, 0},
         '{0, 0,   0, 0, 0,  0, 0, 1, 1,  1, 4, 0},
         '{0, 0,   0, 0, 1,  0, 0, 1, 1,  1, 4, 0},
         '{0, 0,   0, 0, 0,  0, 0, 0, 0,  1, 4, 0},
         // gaps, valid held outside ACTIVE, ignored start/ack/eof
         '{0, 1,   9, 0, 0,  0, 0, 0, 0,  1, 4, 0},
         '{1, 1,   9, 0, 0,  0, 0, 0, 0,  1, 4, 0},
         '{0, 1,   9, 0, 0,  0, 1, 0, 1,  1, 0, 0},
         '{0, 1,   9, 0, 0,  1, 0, 0, 1,  1, 0, 0},
         '{0, 0, 200, 0, 0,  1, 0, 0, 1,  1, 1, 0},
         '{1, 1, 200, 0, 0,  1, 0, 0, 1,  1, 1, 0},
         '{0, 0,   0, 0, 0,  1, 0, 0, 1,  1, 2, 0},
         '{0, 1,   9, 0, 1,  1, 0, 0, 1,  1, 2, 0},
         '{0, 0,   0, 1, 0,  1, 0, 0, 1,  1, 3, 0},
         '{0, 1, 128, 1, 0,  1, 0, 0, 1,  1, 3, 0},
         '{0, 1,  50, 0, 0,  0, 0, 0, 1,  1, 4, 0},
         '{0, 1,  50, 0, 0,  0, 0, 1, 1,  1, 4, 0},
         '{0, 1,  50, 0, 0,  0, 0, 1, 1,  1, 4, 0},
         '{0, 1,  50, 0, 1,  0, 0, 1, 1,  1, 4, 0},
         '{0, 0,   0, 0, 0,  0, 0, 0, 0,  1, 4, 0}
      };

      n_vec = 0;
      n_err = 0;
      cyc = 0;
      model_cnt = 0;
      bit3_pulses = 0;
      watch_no_done = 1'b0;
      i_clear = 1'b1;
      i_start_frame = 1'b0;
      i_pix_data = '0;
      i_pix_valid = 1'b0;
      i_pix_eof = 1'b0;
      i_done_ack = 1'b0;

      fork
         monitor();
      join_none

      // Reset held for two cycles
      for (int r = 0; r < 2; r++) begin
         @(negedge i_clk);
         chk($sformatf("rst%0d_hclr", r), int'(o_hist_clear), 1);
         chk($sformatf("rst%0d_ready", r), int'(o_pix_ready), 0);
         chk($sformatf("rst%0d_done", r), int'(o_frame_done), 0);
         chk($sformatf("rst%0d_busy", r), int'(o_busy), 0);
         chk($sformatf("rst%0d_en", r), int'(o_counter_en != '0), 0);
         chk($sformatf("rst%0d_cnt", r), int'(o_pix_count), 0);
         chk($sformatf("rst%0d_sat", r), int'(o_sat_err), 0);
      end
      cyc_step();
      i_clear = 1'b0;

      // Table-driven frames
      for (int i = 0; i < 25; i++) begin
         i_start_frame = (vt[i].start != 0);
         i_pix_valid   = (vt[i].valid != 0);
         i_pix_data    = 8'(vt[i].data);
         i_pix_eof     = (vt[i].eof != 0);
         i_done_ack    = (vt[i].ack != 0);
         @(negedge i_clk);
         chk($sformatf("r%0d_ready", i), int'(o_pix_ready), vt[i].e_ready);
         chk($sformatf("r%0d_hclr", i), int'(o_hist_clear), vt[i].e_hclr);
         chk($sformatf("r%0d_done", i), int'(o_frame_done), vt[i].e_done);
         chk($sformatf("r%0d_busy", i), int'(o_busy), vt[i].e_busy);
         if (vt[i].chk != 0) begin
            chk($sformatf("r%0d_cnt", i), int'(o_pix_count), vt[i].e_cnt);
            chk($sformatf("r%0d_sat", i), int'(o_sat_err), vt[i].e_sat);
         end
         cyc_step();
      end
      i_start_frame = 1'b0;
      i_pix_valid   = 1'b0;
      i_pix_eof     = 1'b0;
      i_done_ack    = 1'b0;

      // Saturation: 32769 pixels of value 3
      p0 = bit3_pulses;
      start_pulse();
      for (int n = 1; n <= MAX_PIX + 2; n++) begin
         send_beat(8'd3, n == MAX_PIX + 2);
      end
      wait_done("sat", MAX_PIX, 1);
      chk("sat_bit3_pulses", bit3_pulses - p0, MAX_PIX);

      // Back-to-back: start in DONE without acknowledge
      start_pulse();
      @(negedge i_clk);
      chk("b2b_hclr", int'(o_hist_clear), 1);
      chk("b2b_cnt_cleared", int'(o_pix_count), 0);
      chk("b2b_sat_cleared", int'(o_sat_err), 0);
      cyc_step();
      send_beat(8'd10, 1'b0);
      send_beat(8'd20, 1'b1);
      wait_done("b2b", 2, 0);
      ack_done();
      @(negedge i_clk);
      chk("b2b_idle_busy", int'(o_busy), 0);
      cyc_step();

      // Abort with clear mid-ACTIVE
      start_pulse();
      send_beat(8'd40, 1'b0);
      send_beat(8'd41, 1'b0);
      i_pix_valid = 1'b1;
      i_pix_data  = 8'd42;
      i_clear     = 1'b1;
      @(negedge i_clk);
      chk("abort_hclr", int'(o_hist_clear), 1);
      chk("abort_en_in_clear", int'(o_counter_en != '0), 0);
      cyc_step();
      i_clear = 1'b0;
      watch_no_done = 1'b1;
      @(negedge i_clk);
      chk("abort_busy", int'(o_busy), 0);
      chk("abort_ready", int'(o_pix_ready), 0);
      chk("abort_en", int'(o_counter_en != '0), 0);
      repeat (6) cyc_step();
      i_pix_valid = 1'b0;
      watch_no_done = 1'b0;
      start_pulse();
      send_beat(8'd1, 1'b0);
      send_beat(8'd2, 1'b0);
      send_beat(8'd254, 1'b1);
      wait_done("post_abort", 3, 0);
      ack_done();
      repeat (2) cyc_step();
      chk("sb_drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
